// File: rtl/conversor_bcd_pkg.sv
// Shared types and constants for the binary-to-BCD converter.
package conversor_bcd_pkg;

   localparam int unsigned LARGURA_DIGITO = 4;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      DESLOCA = 2'd1,
      FIM     = 2'd2
   } estado_t;

endpackage

// File: rtl/conversor_bcd_corrige_digito.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more.
module corrige_digito
   import conversor_bcd_pkg::*;
(
   input  logic [LARGURA_DIGITO-1:0] digito_i,
   output logic [LARGURA_DIGITO-1:0] digito_o
);

   assign digito_o = (digito_i >= LARGURA_DIGITO'(5)) ? digito_i + LARGURA_DIGITO'(3) : digito_i;

endmodule

// File: rtl/conversor_bcd.sv
// Iterative shift-and-add-3 binary-to-BCD converter with registered result,
// busy flag, one-cycle done pulse and sticky overflow.
module conversor_bcd
   import conversor_bcd_pkg::*;
#(
   parameter int unsigned LARGURA = 8,
   parameter int unsigned DIGITOS = 3
) (
   input  logic                                clock,
   input  logic                                reset_n,
   input  logic                                inicio,
   input  logic [LARGURA-1:0]                  valor,
   output logic                                ocupado,
   output logic                                pronto,
   output logic [LARGURA_DIGITO*DIGITOS-1:0]   bcd,
   output logic                                estouro
);

   localparam int unsigned BW     = LARGURA_DIGITO * DIGITOS;
   localparam int unsigned CW     = $clog2(LARGURA + 1);
   localparam int unsigned CONC_W = BW + LARGURA;

   estado_t             estado_q;
   logic [LARGURA-1:0]  desloc_q;
   logic [LARGURA-1:0]  desloc_d;
   logic [BW-1:0]       trab_q;
   logic [BW-1:0]       trab_d;
   logic [BW-1:0]       corr;
   logic [CW-1:0]       cont_q;
   logic                estouro_trab_q;
   logic                ocupado_q;
   logic                pronto_q;
   logic [BW-1:0]       bcd_q;
   logic                estouro_q;
   logic [CONC_W-1:0]   conc_sh;

   // One corrector per working digit, all evaluated in parallel
   for (genvar g = 0; g < DIGITOS; g++) begin : g_corr
      corrige_digito u_corrige (
         .digito_i (trab_q[g*LARGURA_DIGITO +: LARGURA_DIGITO]),
         .digito_o (corr[g*LARGURA_DIGITO +: LARGURA_DIGITO])
      );
   end

   assign conc_sh  = {corr, desloc_q} << 1;
   assign trab_d   = conc_sh[CONC_W-1:LARGURA];
   assign desloc_d = conc_sh[LARGURA-1:0];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         estado_q       <= OCIOSO;
         desloc_q       <= '0;
         trab_q         <= '0;
         cont_q         <= '0;
         estouro_trab_q <= 1'b0;
         ocupado_q      <= 1'b0;
         pronto_q       <= 1'b0;
         bcd_q          <= '0;
         estouro_q      <= 1'b0;
      end else begin
         pronto_q <= 1'b0;
         case (estado_q)
            OCIOSO: begin
               if (inicio) begin
                  desloc_q       <= valor;
                  trab_q         <= '0;
                  estouro_trab_q <= 1'b0;
                  cont_q         <= CW'(LARGURA);
                  ocupado_q      <= 1'b1;
                  estado_q       <= DESLOCA;
               end
            end
            DESLOCA: begin
               desloc_q       <= desloc_d;
               trab_q         <= trab_d;
               // Bit leaving the top digit means the value needs more digits
               estouro_trab_q <= estouro_trab_q | corr[BW-1];
               cont_q         <= cont_q - CW'(1);
               if (cont_q == CW'(1)) begin
                  estado_q <= FIM;
               end
            end
            FIM: begin
               bcd_q     <= trab_q;
               estouro_q <= estouro_trab_q;
               pronto_q  <= 1'b1;
               ocupado_q <= 1'b0;
               estado_q  <= OCIOSO;
            end
            default: begin
               ocupado_q <= 1'b0;
               estado_q  <= OCIOSO;
            end
         endcase
      end
   end

   assign ocupado = ocupado_q;
   assign pronto  = pronto_q;
   assign bcd     = bcd_q;
   assign estouro = estouro_q;

endmodule
